// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: state encodings, register constants
// and a small helper used by the dependency comparators.
package hazard_unit_pkg;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int STALL_CNT_W = 16;

  typedef enum logic {
    ST_IDLE = S_IDLE,
    ST_BUSY = S_BUSY
  } md_state_t;

  // Pipeline-register control bundle driven by the priority mux.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } pipe_ctrl_t;

  // A producer only creates a dependency when it really writes a register:
  // $zero is hardwired, so a load into r0 never blocks anything.
  function automatic logic reg_dep(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit_md_timer.sv
// Busy-window tracker for the multi-cycle multiply/divide unit.
// A start loads the op latency; the counter then runs down to 1, and the
// cycle at count 1 is the HI/LO write cycle (done).
module md_timer
  import hazard_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);

  md_state_t       state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   load_val;

  assign load_val = is_div ? DIV_LOAD : MULT_LOAD;

  // FSM, down-counter and registered busy/done; done is precomputed one
  // cycle ahead so it is high exactly while the count sits at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_BUSY;
            count <= load_val;
            busy  <= 1'b1;
            done  <= (load_val == CNT_ONE);
          end
        end
        ST_BUSY: begin
          if (count == CNT_ONE) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            count <= count - CNT_ONE;
            done  <= (count == CNT_TWO);
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the five-stage pipeline. Detects load-use and
// multiply/divide result hazards, applies taken-branch flushes, and counts
// stall cycles. The mul/div busy window lives in md_timer.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        id_md_start,
  input  logic        id_md_div,
  input  logic        id_hilo_read,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  logic       load_use;
  logic       md_hazard;
  logic       md_accept;
  pipe_ctrl_t ctrl;

  assign load_use  = ex_memread &&
                     (reg_dep(ex_rd, id_rs) || (id_uses_rt && reg_dep(ex_rd, id_rt)));

  // A new mul/div must also wait: it would overwrite HI/LO of the op in flight.
  assign md_hazard = md_busy && (id_hilo_read || id_md_start);

  // The start only counts once the instruction actually leaves ID.
  assign md_accept = id_md_start && !branch_taken && !md_hazard && !load_use;

  // Priority mux: branch flush beats any stall, stalls beat normal flow.
  always_comb begin
    ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
    if (branch_taken) begin
      ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
    end else if (md_hazard || load_use) begin
      ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;

  md_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_accept),
    .is_div (id_md_div),
    .busy   (md_busy),
    .done   (md_done)
  );

  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Saturating stall-cycle counter: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (!pc_write && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
